// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and
// the alignment rule used at request accept.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_BAD  = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4
    } lsu_state_e;

    // A request is rejected if it is not naturally aligned or has no valid size.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Lane logic for little-endian sub-word accesses: extracts/extends a load
// lane from a memory word and merges store data into one lane of a word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [31:0] byte_w;
    logic [31:0] half_w;

    assign bsh    = {off, 3'b000};
    assign hsh    = {off[1], 4'b0000};
    assign byte_w = word >> bsh;
    assign half_w = word >> hsh;

    // Select the addressed lane for loads and build the merged word for stores.
    always_comb begin
        load_data = word;
        merged    = wdata;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sign_ext & byte_w[7]}}, byte_w[7:0]};
                merged    = (word & ~(32'h0000_00FF << bsh)) | ({24'd0, wdata[7:0]} << bsh);
            end
            SZ_HALF: begin
                load_data = {{16{sign_ext & half_w[15]}}, half_w[15:0]};
                merged    = (word & ~(32'h0000_FFFF << hsh)) | ({16'd0, wdata[15:0]} << hsh);
            end
            default: begin
                load_data = word;
                merged    = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-wide memory. Sub-word stores are done
// as read-modify-write; misaligned or invalid requests get an error response.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    lsu_state_e        state_q;
    lsu_state_e        state_d;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [31:0]       word_q;
    logic [31:0]       lane_load;
    logic [31:0]       lane_merged;
    logic              accept;
    logic              req_bad;

    assign accept  = (state_q == IDLE) && req_valid;
    assign req_bad = misaligned(req_size, req_addr[1:0]);

    lsu_lane u_lane (
        .size      (size_q),
        .sign_ext  (sgn_q),
        .off       (addr_q[1:0]),
        .word      (mem_rd),
        .wdata     (word_q),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    // State register; reset aborts any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Request capture and per-state data registers; only meaningful while the
    // FSM is busy, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            size_q  <= req_size;
            sgn_q   <= req_signed;
            addr_q  <= req_addr;
            err_q   <= req_bad;
            rdata_q <= 32'd0;
            word_q  <= req_wdata;
        end else if (state_q == LOAD) begin
            rdata_q <= lane_load;
        end else if (state_q == RMW_RD) begin
            word_q  <= lane_merged;
        end
    end

    // Next state and all outputs, decoded from the current state.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'd0;
        mem_we     = 1'b0;
        mem_a      = '0;
        mem_wd     = 32'd0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad)               state_d = RESP;
                    else if (!req_we)          state_d = LOAD;
                    else if (req_size == SZ_WORD) state_d = WR;
                    else                       state_d = RMW_RD;
                end
            end
            LOAD: begin
                mem_a   = {addr_q[ADDR_W-1:2], 2'b00};
                state_d = RESP;
            end
            RMW_RD: begin
                mem_a   = {addr_q[ADDR_W-1:2], 2'b00};
                state_d = WR;
            end
            WR: begin
                mem_a   = {addr_q[ADDR_W-1:2], 2'b00};
                mem_we  = 1'b1;
                mem_wd  = word_q;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = rdata_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a small word memory model.
module tb_lsu_rmw;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:63];
    int          nvec = 0;
    int          nerr = 0;
    int          we_cnt = 0;
    int          resp_cnt = 0;
    logic [31:0] we_addr = 32'd0;
    logic [31:0] we_data = 32'd0;

    always #5 clk = ~clk;

    lsu_rmw #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    assign mem_rd = mem[mem_a[7:2]];

    // Memory model writes mid-cycle; also logs write strobes and responses.
    always @(negedge clk) begin
        if (mem_we) begin
            mem[mem_a[7:2]] = mem_wd;
            we_cnt  = we_cnt + 1;
            we_addr = mem_a;
            we_data = mem_wd;
        end
        if (resp_valid) resp_cnt = resp_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec = nvec + 1;
        if (got !== exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request from IDLE and wait (bounded) for its response.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rdata, output logic err);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; rdata = 32'hxxxx_xxxx; err = 1'bx;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = i; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
        if (lat == 0) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    int          w0;
    int          r0;
    int          acc;
    logic        prev_resp;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        #12;
        chk("rst_outputs", {26'd0, req_ready, resp_valid, resp_err, mem_we, 2'b00},
            {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
        chk("rst_data", resp_rdata | mem_a | mem_wd, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Word store then word load at 0x10.
        w0 = we_cnt;
        do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er);
        chk("wst_we_count", we_cnt - w0, 1);
        chk("wst_we_addr", we_addr, 32'h10);
        chk("wst_we_data", we_data, 32'hDEADBEEF);
        chk("wst_latency", lat, 2);
        chk("wst_resp", {rd[30:0], er}, 32'd0);
        w0 = we_cnt;
        do_req(1'b0, SZ_WORD, 1'b1, 32'h10, 32'h0, lat, rd, er);
        chk("wld_data", rd, 32'hDEADBEEF);
        chk("wld_err", er, 0);
        chk("wld_latency", lat, 2);
        chk("wld_no_write", we_cnt - w0, 0);

        // Byte and half stores as read-modify-write at 0x20.
        @(negedge clk); mem[8] = 32'h11223344;
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h21, 32'hFFFFFFAA, lat, rd, er);
        chk("bst_we_data", we_data, 32'h1122AA44);
        chk("bst_we_addr", we_addr, 32'h20);
        chk("bst_latency", lat, 3);
        chk("bst_resp", {rd[30:0], er}, 32'd0);
        do_req(1'b1, SZ_HALF, 1'b1, 32'h22, 32'h1234BEEF, lat, rd, er);
        chk("hst_mem", mem[8], 32'hBEEFAA44);
        chk("hst_latency", lat, 3);

        // Sub-word loads with zero and sign extension at 0x30.
        @(negedge clk); mem[12] = 32'h8000FF80;
        do_req(1'b0, SZ_BYTE, 1'b1, 32'h30, 32'h0, lat, rd, er);
        chk("lb_s_30", rd, 32'hFFFFFF80);
        do_req(1'b0, SZ_HALF, 1'b0, 32'h32, 32'h0, lat, rd, er);
        chk("lh_u_32", rd, 32'h00008000);
        do_req(1'b0, SZ_HALF, 1'b1, 32'h32, 32'h0, lat, rd, er);
        chk("lh_s_32", rd, 32'hFFFF8000);
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h31, 32'h0, lat, rd, er);
        chk("lb_u_31", rd, 32'h000000FF);
        do_req(1'b0, SZ_BYTE, 1'b1, 32'h33, 32'h0, lat, rd, er);
        chk("lb_s_33", rd, 32'hFFFFFF80);
        do_req(1'b0, SZ_HALF, 1'b1, 32'h30, 32'h0, lat, rd, er);
        chk("lh_s_30", rd, 32'hFFFFFF80);

        // Misaligned and invalid-size requests.
        @(negedge clk); mem[16] = 32'hCAFEF00D;
        w0 = we_cnt;
        do_req(1'b0, SZ_HALF, 1'b0, 32'h41, 32'h0, lat, rd, er);
        chk("mis_lh_err", er, 1);
        chk("mis_lh_rdata", rd, 32'd0);
        do_req(1'b1, SZ_WORD, 1'b0, 32'h42, 32'h12345678, lat, rd, er);
        chk("mis_sw_err", er, 1);
        chk("mis_sw_rdata", rd, 32'd0);
        do_req(1'b1, SZ_BAD, 1'b0, 32'h40, 32'h12345678, lat, rd, er);
        chk("bad_size_err", er, 1);
        chk("bad_size_rdata", rd, 32'd0);
        chk("mis_no_write", we_cnt - w0, 0);
        chk("mis_mem_kept", mem[16], 32'hCAFEF00D);

        // Reset during RMW_RD of a byte store.
        @(negedge clk); mem[20] = 32'h55667788;
        w0 = we_cnt; r0 = resp_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_addr = 32'h52; req_wdata = 32'h99;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("rst_rmw_mem_a", mem_a, 32'h50);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rmw_ready", req_ready, 1);
        chk("rst_rmw_outs", {29'd0, mem_we, resp_valid, resp_err} | mem_a | mem_wd, 32'd0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_rmw_no_write", we_cnt - w0, 0);
        chk("rst_rmw_no_resp", resp_cnt - r0, 0);
        chk("rst_rmw_mem", mem[20], 32'h55667788);

        // Reset while in WR of a byte store.
        w0 = we_cnt; r0 = resp_cnt;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 chk("rst_wr_in_wr", mem_we, 1);
        #1 rst_n = 1'b0;
        #1 chk("rst_wr_we_off", mem_we, 0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_wr_no_write", we_cnt - w0, 0);
        chk("rst_wr_no_resp", resp_cnt - r0, 0);
        chk("rst_wr_mem", mem[20], 32'h55667788);

        // req_valid held high: accepts only in the cycle after each response.
        r0 = resp_cnt; acc = 0; prev_resp = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (req_ready) begin
                if (acc > 0) chk("hold_accept_after_resp", prev_resp, 1);
                acc = acc + 1;
            end
            if (resp_valid) chk("hold_rdata", resp_rdata, 32'hDEADBEEF);
            prev_resp = resp_valid;
        end
        req_valid = 1'b0;
        chk("hold_accept_count", acc, 4);
        @(negedge clk);
        chk("hold_resp_count", resp_cnt - r0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
